// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the memory port arbiter slice.
//   arb_state_e  : arbiter FSM states (IDLE, WR_OWN, RD_OWN)
//   owner_e      : requester identity, used for the round-robin pointer
//   MAX_BEATS_DEF: beats an owner may hold the port without presenting last
//   RD_LATENCY   : cycles from a read grant to returned read data
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_OWN = 2'd1,
        RD_OWN = 2'd2
    } arb_state_e;

    typedef enum logic {
        WR = 1'b0,
        RD = 1'b1
    } owner_e;

    localparam int MAX_BEATS_DEF = 256;
    localparam int RD_LATENCY    = 2;

    // The requester that is not 'o'; the pointer always lands here on release.
    function automatic owner_e other_owner(input owner_e o);
        return (o == WR) ? RD : WR;
    endfunction

endpackage

// File: rtl/mem_arb_rd_pipe.sv
// ---------------------------------------------------------------------------
// mem_arb_rd_pipe
// Fixed-latency valid delay line for read returns. An asynchronous clear
// drops every in-flight read so nothing surfaces after reset.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low clear
//   in_valid  : read beat transferred this cycle
//   out_valid : in_valid delayed by LATENCY cycles
// ---------------------------------------------------------------------------
module mem_arb_rd_pipe
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = RD_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic out_valid
);

    logic [LATENCY-1:0] pipe_q;
    logic [LATENCY-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign out_valid = pipe_q[LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Burst-locked round-robin arbiter sharing a single-port memory between the
// write-data engine and the read-data engine.
//   ACLK, ARESETn            : clock / asynchronous active-low reset
//   wr_req/wr_last/wr_addr/wr_data : write engine beat request
//   rd_req/rd_last/rd_addr   : read engine beat request
//   wr_gnt / rd_gnt          : beat accepted this cycle (req & gnt)
//   rd_data / rd_dvalid      : read return, aligned to memory latency
//   arb_err                  : one-cycle pulse after a forced release
//   mem_en/mem_we/mem_addr/mem_wdata : registered memory command bus
//   mem_rdata                : memory read data, one cycle after read enable
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 1024,
    parameter  int MAX_BEATS  = MAX_BEATS_DEF,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  wr_req,
    input  logic                  wr_last,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic                  rd_last,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  wr_gnt,
    output logic                  rd_gnt,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_dvalid,
    output logic                  arb_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    arb_state_e            state_q, state_d;
    owner_e                ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  arb_err_q, arb_err_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  wr_gnt_c, rd_gnt_c;
    logic                  xfer;
    owner_e                owner;
    logic                  beat_last;
    logic [ADDR_W-1:0]     beat_addr;

    // Grants are a pure function of ownership: the owner sees gnt = req,
    // the other side is locked out until the burst ends.
    always_comb begin
        wr_gnt_c = 1'b0;
        rd_gnt_c = 1'b0;
        case (state_q)
            WR_OWN:  wr_gnt_c = wr_req;
            RD_OWN:  rd_gnt_c = rd_req;
            default: ;
        endcase
    end

    assign xfer      = wr_gnt_c | rd_gnt_c;
    assign owner     = (state_q == RD_OWN) ? RD : WR;
    assign beat_last = rd_gnt_c ? rd_last : wr_last;
    assign beat_addr = rd_gnt_c ? rd_addr : wr_addr;

    // Arbitration and burst tracking. A release (last, or the MAX_BEATS-th
    // beat without last) always returns to IDLE and hands priority to the
    // other requester; the forced case additionally raises arb_err.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        arb_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req && (!rd_req || ptr_q == WR)) begin
                    state_d = WR_OWN;
                    cnt_d   = '0;
                end else if (rd_req) begin
                    state_d = RD_OWN;
                    cnt_d   = '0;
                end
            end
            WR_OWN, RD_OWN: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (beat_last) begin
                        state_d = IDLE;
                        ptr_d   = other_owner(owner);
                    end else if (cnt_q == LAST_CNT) begin
                        state_d   = IDLE;
                        ptr_d     = other_owner(owner);
                        arb_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory command bus: a transfer is issued on the next cycle; idle cycles
    // deassert the strobes but keep address and write data stable.
    always_comb begin
        mem_en_d    = xfer;
        mem_we_d    = wr_gnt_c;
        mem_addr_d  = xfer ? beat_addr : mem_addr_q;
        mem_wdata_d = wr_gnt_c ? wr_data : mem_wdata_q;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            ptr_q       <= WR;
            cnt_q       <= '0;
            arb_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            arb_err_q   <= arb_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Stage 1 of this delay coincides with mem_en & ~mem_we on the bus;
    // stage 2 lines up with the memory's registered read data.
    mem_arb_rd_pipe #(
        .LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .in_valid  (rd_req & rd_gnt_c),
        .out_valid (rd_dvalid)
    );

    assign wr_gnt    = wr_gnt_c;
    assign rd_gnt    = rd_gnt_c;
    assign rd_data   = mem_rdata;
    assign arb_err   = arb_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a behavioural single-port memory.
// A stimulus table covers round robin, a single write burst, read latency and
// the stall/lock case; hand-written sequences cover forced release and reset
// in the middle of a read burst.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DW     = 32;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;
    localparam int NROWS  = 31;

    logic          ACLK;
    logic          ARESETn;
    logic          wr_req, wr_last, rd_req, rd_last;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt, rd_gnt, rd_dvalid, arb_err, mem_en, mem_we;
    logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_checks;
    int n_fail;
    int err_pulses;

    typedef struct {
        logic          wr_req;
        logic          wr_last;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          rd_req;
        logic          rd_last;
        logic [AW-1:0] rd_addr;
        logic          e_wr_gnt;
        logic          e_rd_gnt;
        logic          e_mem_en;
        logic          e_mem_we;
        logic [AW-1:0] e_mem_addr;
        logic [DW-1:0] e_mem_wdata;
        logic          e_dvalid;
        logic [DW-1:0] e_rd_data;
        logic          e_err;
    } vec_t;

    vec_t tbl [NROWS];
    logic [DW-1:0] mem [DEPTH];

    mem_port_arbiter dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .wr_req    (wr_req),
        .wr_last   (wr_last),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_last   (rd_last),
        .rd_addr   (rd_addr),
        .wr_gnt    (wr_gnt),
        .rd_gnt    (rd_gnt),
        .rd_data   (rd_data),
        .rd_dvalid (rd_dvalid),
        .arb_err   (arb_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Memory model: while in reset every word holds 0xC000_0000 | address,
    // except the two preloaded words used by the read latency sequence.
    always @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hC000_0000 | 32'(i);
            mem[5]    <= 32'h0000_1234;
            mem[6]    <= 32'h0000_5678;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    always @(negedge ACLK) begin
        if (arb_err === 1'b1) err_pulses++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wr_req  = v.wr_req;
        wr_last = v.wr_last;
        wr_addr = v.wr_addr;
        wr_data = v.wr_data;
        rd_req  = v.rd_req;
        rd_last = v.rd_last;
        rd_addr = v.rd_addr;
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        checkOutput($sformatf("row%0d.wr_gnt", idx),    32'(wr_gnt),    32'(v.e_wr_gnt));
        checkOutput($sformatf("row%0d.rd_gnt", idx),    32'(rd_gnt),    32'(v.e_rd_gnt));
        checkOutput($sformatf("row%0d.mem_en", idx),    32'(mem_en),    32'(v.e_mem_en));
        checkOutput($sformatf("row%0d.mem_we", idx),    32'(mem_we),    32'(v.e_mem_we));
        checkOutput($sformatf("row%0d.mem_addr", idx),  32'(mem_addr),  32'(v.e_mem_addr));
        checkOutput($sformatf("row%0d.mem_wdata", idx), mem_wdata,      v.e_mem_wdata);
        checkOutput($sformatf("row%0d.rd_dvalid", idx), 32'(rd_dvalid), 32'(v.e_dvalid));
        checkOutput($sformatf("row%0d.arb_err", idx),   32'(arb_err),   32'(v.e_err));
        if (v.e_dvalid)
            checkOutput($sformatf("row%0d.rd_data", idx), rd_data, v.e_rd_data);
    endtask

    task automatic nextCycle();
        @(posedge ACLK);
        #1;
    endtask

    task automatic driveIdle();
        wr_req = 0; wr_last = 0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_last = 0; rd_addr = '0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        err_pulses = 0;

        //        wq wl wa      wd        rq rl ra     | wg rg en we ma      mwd      dv rdd            err
        // round robin after reset: write first, then read
        tbl[0]  = '{1, 0, 'h020, 'hB0, 1, 0, 'h030,  0, 0, 0, 0, 'h000, 'h00, 0, 0, 0};
        tbl[1]  = '{1, 0, 'h020, 'hB0, 1, 0, 'h030,  1, 0, 0, 0, 'h000, 'h00, 0, 0, 0};
        tbl[2]  = '{1, 1, 'h021, 'hB1, 1, 0, 'h030,  1, 0, 1, 1, 'h020, 'hB0, 0, 0, 0};
        tbl[3]  = '{0, 0, 'h021, 'hB1, 1, 0, 'h030,  0, 0, 1, 1, 'h021, 'hB1, 0, 0, 0};
        tbl[4]  = '{0, 0, 'h000, 'h00, 1, 0, 'h030,  0, 1, 0, 0, 'h021, 'hB1, 0, 0, 0};
        tbl[5]  = '{0, 0, 'h000, 'h00, 1, 1, 'h031,  0, 1, 1, 0, 'h030, 'hB1, 0, 0, 0};
        tbl[6]  = '{0, 0, 'h000, 'h00, 0, 0, 'h000,  0, 0, 1, 0, 'h031, 'hB1, 1, 'hC000_0030, 0};
        // single 4-beat write burst, 0x010..0x013 / 0xA0..0xA3
        tbl[7]  = '{1, 0, 'h010, 'hA0, 0, 0, 'h000,  0, 0, 0, 0, 'h031, 'hB1, 1, 'hC000_0031, 0};
        tbl[8]  = '{1, 0, 'h010, 'hA0, 0, 0, 'h000,  1, 0, 0, 0, 'h031, 'hB1, 0, 0, 0};
        tbl[9]  = '{1, 0, 'h011, 'hA1, 0, 0, 'h000,  1, 0, 1, 1, 'h010, 'hA0, 0, 0, 0};
        tbl[10] = '{1, 0, 'h012, 'hA2, 0, 0, 'h000,  1, 0, 1, 1, 'h011, 'hA1, 0, 0, 0};
        tbl[11] = '{1, 1, 'h013, 'hA3, 0, 0, 'h000,  1, 0, 1, 1, 'h012, 'hA2, 0, 0, 0};
        // simultaneous request again: pointer now favours read (addr 5, 6)
        tbl[12] = '{1, 0, 'h040, 'hD0, 1, 0, 'h005,  0, 0, 1, 1, 'h013, 'hA3, 0, 0, 0};
        tbl[13] = '{1, 0, 'h040, 'hD0, 1, 0, 'h005,  0, 1, 0, 0, 'h013, 'hA3, 0, 0, 0};
        tbl[14] = '{1, 0, 'h040, 'hD0, 1, 1, 'h006,  0, 1, 1, 0, 'h005, 'hA3, 0, 0, 0};
        tbl[15] = '{1, 0, 'h040, 'hD0, 0, 0, 'h000,  0, 0, 1, 0, 'h006, 'hA3, 1, 'h0000_1234, 0};
        tbl[16] = '{1, 0, 'h040, 'hD0, 0, 0, 'h000,  1, 0, 0, 0, 'h006, 'hA3, 1, 'h0000_5678, 0};
        tbl[17] = '{1, 1, 'h041, 'hD1, 0, 0, 'h000,  1, 0, 1, 1, 'h040, 'hD0, 0, 0, 0};
        tbl[18] = '{0, 0, 'h000, 'h00, 0, 0, 'h000,  0, 0, 1, 1, 'h041, 'hD1, 0, 0, 0};
        tbl[19] = '{0, 0, 'h000, 'h00, 0, 0, 'h000,  0, 0, 0, 0, 'h041, 'hD1, 0, 0, 0};
        // stall and lock: writer drops req for 3 cycles while read waits
        tbl[20] = '{1, 0, 'h050, 'hE0, 0, 0, 'h000,  0, 0, 0, 0, 'h041, 'hD1, 0, 0, 0};
        tbl[21] = '{1, 0, 'h050, 'hE0, 1, 1, 'h007,  1, 0, 0, 0, 'h041, 'hD1, 0, 0, 0};
        tbl[22] = '{0, 0, 'h051, 'hE1, 1, 1, 'h007,  0, 0, 1, 1, 'h050, 'hE0, 0, 0, 0};
        tbl[23] = '{0, 0, 'h051, 'hE1, 1, 1, 'h007,  0, 0, 0, 0, 'h050, 'hE0, 0, 0, 0};
        tbl[24] = '{0, 0, 'h051, 'hE1, 1, 1, 'h007,  0, 0, 0, 0, 'h050, 'hE0, 0, 0, 0};
        tbl[25] = '{1, 1, 'h051, 'hE1, 1, 1, 'h007,  1, 0, 0, 0, 'h050, 'hE0, 0, 0, 0};
        tbl[26] = '{0, 0, 'h000, 'h00, 1, 1, 'h007,  0, 0, 1, 1, 'h051, 'hE1, 0, 0, 0};
        tbl[27] = '{0, 0, 'h000, 'h00, 1, 1, 'h007,  0, 1, 0, 0, 'h051, 'hE1, 0, 0, 0};
        tbl[28] = '{0, 0, 'h000, 'h00, 0, 0, 'h000,  0, 0, 1, 0, 'h007, 'hE1, 0, 0, 0};
        tbl[29] = '{0, 0, 'h000, 'h00, 0, 0, 'h000,  0, 0, 0, 0, 'h007, 'hE1, 1, 'hC000_0007, 0};
        tbl[30] = '{0, 0, 'h000, 'h00, 0, 0, 'h000,  0, 0, 0, 0, 'h007, 'hE1, 0, 0, 0};

        // Reset held with random requests: every output stays at zero.
        ARESETn = 1'b0;
        driveIdle();
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            wr_req = 1'($urandom_range(0, 1));
            rd_req = 1'($urandom_range(0, 1));
            wr_addr = 10'($urandom_range(0, 1023));
            wr_data = $urandom;
            @(negedge ACLK);
            checkOutput("rst.wr_gnt",    32'(wr_gnt),    0);
            checkOutput("rst.rd_gnt",    32'(rd_gnt),    0);
            checkOutput("rst.mem_en",    32'(mem_en),    0);
            checkOutput("rst.mem_we",    32'(mem_we),    0);
            checkOutput("rst.mem_addr",  32'(mem_addr),  0);
            checkOutput("rst.mem_wdata", mem_wdata,      0);
            checkOutput("rst.rd_dvalid", 32'(rd_dvalid), 0);
            checkOutput("rst.arb_err",   32'(arb_err),   0);
            checkOutput("rst.rd_data",   rd_data,        0);
        end
        nextCycle();
        driveIdle();
        ARESETn = 1'b1;

        for (int r = 0; r < NROWS; r++) begin
            applyStimulus(tbl[r]);
            @(negedge ACLK);
            checkVector(r, tbl[r]);
            nextCycle();
        end

        // Forced release: 256 write beats without last while read waits.
        wr_req = 1; wr_last = 0; wr_addr = 10'h100; wr_data = 32'hF000_0000;
        rd_req = 1; rd_last = 1; rd_addr = 10'h008;
        @(negedge ACLK);
        checkOutput("force.arb_wr_gnt", 32'(wr_gnt), 0);
        checkOutput("force.arb_rd_gnt", 32'(rd_gnt), 0);
        nextCycle();
        for (int i = 0; i < 256; i++) begin
            wr_addr = 10'(32'h100 + i);
            wr_data = 32'hF000_0000 + 32'(i);
            @(negedge ACLK);
            checkOutput($sformatf("force.beat%0d.wr_gnt", i), 32'(wr_gnt), 1);
            checkOutput($sformatf("force.beat%0d.rd_gnt", i), 32'(rd_gnt), 0);
            checkOutput($sformatf("force.beat%0d.arb_err", i), 32'(arb_err), 0);
            if (i > 0)
                checkOutput($sformatf("force.beat%0d.mem_addr", i), 32'(mem_addr), 32'h100 + 32'(i) - 1);
            nextCycle();
        end
        wr_addr = 10'h200; wr_data = '0;
        @(negedge ACLK);
        checkOutput("force.rel.wr_gnt",    32'(wr_gnt),   0);
        checkOutput("force.rel.rd_gnt",    32'(rd_gnt),   0);
        checkOutput("force.rel.arb_err",   32'(arb_err),  1);
        checkOutput("force.rel.mem_en",    32'(mem_en),   1);
        checkOutput("force.rel.mem_we",    32'(mem_we),   1);
        checkOutput("force.rel.mem_addr",  32'(mem_addr), 32'h1FF);
        checkOutput("force.rel.mem_wdata", mem_wdata,     32'hF000_00FF);
        nextCycle();
        @(negedge ACLK);
        checkOutput("force.next.rd_gnt",  32'(rd_gnt),  1);
        checkOutput("force.next.wr_gnt",  32'(wr_gnt),  0);
        checkOutput("force.next.arb_err", 32'(arb_err), 0);
        nextCycle();
        driveIdle();
        for (int c = 0; c < 4; c++) nextCycle();
        checkOutput("force.err_pulses", 32'(err_pulses), 1);

        // Reset in the middle of a read burst drops in-flight returns.
        rd_req = 1; rd_last = 0; rd_addr = 10'h005;
        @(negedge ACLK);
        checkOutput("rstmid.arb_rd_gnt", 32'(rd_gnt), 0);
        nextCycle();
        @(negedge ACLK);
        checkOutput("rstmid.beat0_rd_gnt", 32'(rd_gnt), 1);
        nextCycle();
        rd_addr = 10'h006;
        @(negedge ACLK);
        checkOutput("rstmid.beat1_rd_gnt", 32'(rd_gnt), 1);
        nextCycle();
        @(negedge ACLK);
        checkOutput("rstmid.pre_dvalid", 32'(rd_dvalid), 1);
        #1;
        ARESETn = 1'b0;
        #1;
        checkOutput("rstmid.async_dvalid", 32'(rd_dvalid), 0);
        checkOutput("rstmid.async_rd_gnt", 32'(rd_gnt),    0);
        checkOutput("rstmid.async_mem_en", 32'(mem_en),    0);
        @(posedge ACLK);
        nextCycle();
        ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput("rstmid.rel_dvalid", 32'(rd_dvalid), 0);
        checkOutput("rstmid.rel_rd_gnt", 32'(rd_gnt),    0);
        nextCycle();
        @(negedge ACLK);
        checkOutput("rstmid.cyc1_rd_gnt", 32'(rd_gnt), 1);
        nextCycle();
        driveIdle();
        for (int c = 0; c < 4; c++) nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
